inv_sub_bytes_seq: RTL and testbench

Sequencer that performs AES InvSubBytes on a 128-bit state by time-sharing LANES instances of the combinational InvSBox (8-bit in_toSub -> 8-bit out_Subed). It sits in the decryption round datapath between InvShiftRows and AddRoundKey. It trades InvSBox area against latency under a start/busy/done handshake.

---
 rtl/inv_sub_bytes_seq.sv | 107 ++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes sequencer: substitutes a 128-bit state LANES bytes per cycle using LANES InvSBox lanes.
// Optional abort input enabled by defining INV_SUB_BYTES_ABORT_EN.
module inv_sub_bytes_seq #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
`ifdef INV_SUB_BYTES_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  // Entry i is InvSBox(i); element [0] sits in the most significant byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    work;
  logic [127:0]    sub_work;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // Each lane reads its byte from the working register only, so no lane ever sees X.
  always_comb begin
    // NOTE: sub_work gets a full default before the partial writes, otherwise a latch is inferred.
    sub_work = work;
    for (int j = 0; j < LANES; j++) begin
      int idx;
      idx         = (int'(cnt) * LANES + j) % 16;
      lane_in[j]  = work[127 - 8*idx -: 8];
      lane_out[j] = INV_SBOX[lane_in[j]];
      sub_work[127 - 8*idx -: 8] = lane_out[j];
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      state_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
`ifdef INV_SUB_BYTES_ABORT_EN
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else
`endif
          begin
            work <= sub_work;
            if (cnt == LAST) begin
              state_out <= sub_work;
              state     <= FINISH;
              cnt       <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          // IDLE and FINISH both accept a new block, giving back-to-back throughput.
          if (start) begin
            work  <= state_in;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: LANES=1, 4 and 16 instances share one stimulus stream.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [127:0] state_in;
  logic         busy1, done1, busy4, done4, busy16, done16;
  logic [127:0] out1, out4, out16;

  localparam logic [127:0] VEC_63 = {16{8'h63}};
  localparam logic [127:0] VEC_A  = {4{32'h007ced16}};
  localparam logic [127:0] EXP_A  = {4{32'h520153ff}};

  int vectors = 0;
  int miscompares = 0;

  int lat1, lat4, lat16, dc1, dc4, bc1;
  logic [127:0] r1, r4, r16;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
`ifdef INV_SUB_BYTES_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .done(done1), .state_out(out1));

  inv_sub_bytes_seq #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
`ifdef INV_SUB_BYTES_ABORT_EN
    .abort(abort),
`endif
    .busy(busy4), .done(done4), .state_out(out4));

  inv_sub_bytes_seq #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
`ifdef INV_SUB_BYTES_ABORT_EN
    .abort(abort),
`endif
    .busy(busy16), .done(done16), .state_out(out16));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One block from an idle DUT over a fixed 21-edge window; n=0 is the accept edge.
  task automatic run_block(input logic [127:0] din, input bit mid_start, input bit abort_at2);
    lat1 = -1; lat4 = -1; lat16 = -1; dc1 = 0; dc4 = 0; bc1 = 0;
    r1 = 'x; r4 = 'x; r16 = 'x;
    @(negedge clk);
    state_in = din;
    start    = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) state_in = ~din;
      start = mid_start && (n == 5);
      abort = abort_at2 && (n == 1);
      if (busy1) bc1++;
      if (done1) begin
        dc1++;
        if (lat1 < 0) begin lat1 = n; r1 = out1; end
      end
      if (done4) begin
        dc4++;
        if (lat4 < 0) begin lat4 = n; r4 = out4; end
      end
      if (done16 && lat16 < 0) begin lat16 = n; r16 = out16; end
    end
  endtask

  initial begin
    int k, last_n, dones;
    logic [127:0] ins [3];
    logic [127:0] exps[3];

    // Reset held with start asserted and random data.
    rst_n    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(busy1), 128'(0));
    check("rst_done", 128'(done1), 128'(0));
    check("rst_out", out1, 128'h0);
    check("rst_busy16", 128'(busy16), 128'(0));
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {126'h0, busy1, done1}, 128'h0);

    // All 8'h63 maps to all zero.
    run_block(VEC_63, 1'b0, 1'b0);
    check("v63_out", r1, 128'h0);
    check("v63_lat1", 128'(lat1), 128'(16));
    check("v63_busy_cycles", 128'(bc1), 128'(16));
    check("v63_done_cnt", 128'(dc1), 128'(1));
    check("v63_lat4", 128'(lat4), 128'(4));
    check("v63_lat16", 128'(lat16), 128'(1));

    // Mixed vector, state_in flipped and start pulsed during RUN.
    run_block(VEC_A, 1'b1, 1'b0);
    check("a_out1", r1, EXP_A);
    check("a_lat1", 128'(lat1), 128'(16));
    check("a_done_cnt", 128'(dc1), 128'(1));
    check("a_out1_hold", out1, EXP_A);
    check("a_out4", r4, EXP_A);
    check("a_lat4", 128'(lat4), 128'(4));
    check("a_out16", r16, EXP_A);
    check("a_lat16", 128'(lat16), 128'(1));

    // Start held high: each FINISH cycle accepts the next block.
    ins[0] = VEC_A;  ins[1] = VEC_63; ins[2] = VEC_A;
    exps[0] = EXP_A; exps[1] = 128'h0; exps[2] = EXP_A;
    k = 0; last_n = 0;
    @(negedge clk);
    state_in = ins[0];
    start    = 1'b1;
    for (int n = 0; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (k > 0 && k < 3 && n == last_n + 1)
        check($sformatf("bb_rebusy%0d", k), {126'h0, busy1, done1}, 128'h2);
      if (done1) begin
        if (k < 3) begin
          check($sformatf("bb_out%0d", k), out1, exps[k]);
          check($sformatf("bb_gap%0d", k), 128'(n - last_n), (k == 0) ? 128'(16) : 128'(17));
          check($sformatf("bb_busy%0d", k), 128'(busy1), 128'(0));
        end
        last_n = n;
        k++;
        if (k < 3) state_in = ins[k];
        else start = 1'b0;
      end
    end
    check("bb_blocks", 128'(k), 128'(3));

    // Reset in RUN cycle 7 discards the block.
    @(negedge clk);
    state_in = VEC_63;
    start    = 1'b1;
    for (int n = 0; n <= 7; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("mid_rst_running", 128'(busy1), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", out1, 128'h0);
    check("mid_rst_flags", {126'h0, busy1, done1}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) dones++;
    end
    check("mid_rst_quiet", 128'(dones), 128'(0));
    run_block(VEC_63, 1'b0, 1'b0);
    check("restart_out", r1, 128'h0);
    check("restart_done_cnt", 128'(dc1), 128'(1));
    check("restart_lat", 128'(lat1), 128'(16));

`ifdef INV_SUB_BYTES_ABORT_EN
    // Abort at RUN cycle 2 keeps the previous result and gives no done.
    run_block(VEC_A, 1'b0, 1'b0);
    check("pre_abort_out", out1, EXP_A);
    run_block(VEC_63, 1'b0, 1'b1);
    check("abort_done1", 128'(dc1), 128'(0));
    check("abort_done4", 128'(dc4), 128'(0));
    check("abort_out1", out1, EXP_A);
    check("abort_out4", out4, EXP_A);
    check("abort_idle", 128'(busy1), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
